// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline stall/flush/freeze controller for a 5-stage MIPS-style core.
//   Forwarding resolves most data hazards. This block handles the remaining
//   cases: load-use hazards, data-cache and instruction-fetch waits, control
//   redirects and HALT. It tracks in-flight destinations in a small
//   EX/MEM/WB scoreboard that shifts in step with the pipeline latches.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   instr_ID     instruction currently in decode
//   ihit / dhit  instruction fetch / data access completes this cycle
//   dmemREN_MEM  load request in MEM
//   dmemWEN_MEM  store request in MEM
//   redirect_EX  taken branch/jump resolved in EX
//   halt_WB      HALT retiring in WB
//   pc_en, ifid_en, idex_en, exmem_en, memwb_en   stage enables
//   ifid_flush, idex_flush, memwb_flush           bubble inserts
//   halted       processor halted
//   stall_cycles count of RUN cycles with pc_en low (wraps)
module hazard_stall_unit #(
  parameter int          CNT_W  = 32,
  parameter logic [4:0]  RA_REG = 5'd31
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      instr_ID,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_MEM,
  input  logic             dmemWEN_MEM,
  input  logic             redirect_EX,
  input  logic             halt_WB,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // ---------------- decode of instr_ID ----------------
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       uses_rs, uses_rt, dec_load;
  logic [4:0] dec_dest;
  sb_entry_t  dec_entry;
  logic       instr_unused;

  assign op           = instr_ID[31:26];
  assign rs           = instr_ID[25:21];
  assign rt           = instr_ID[20:16];
  assign rd           = instr_ID[15:11];
  assign funct        = instr_ID[5:0];
  assign instr_unused = ^instr_ID[10:6];

  always_comb begin
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    dec_dest = 5'd0;
    dec_load = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        dec_dest = (funct == FN_JR) ? 5'd0 : rd;
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_LW: begin
        uses_rs  = 1'b1;
        dec_dest = rt;
        dec_load = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        uses_rs  = 1'b1;
        dec_dest = rt;
      end
      // LUI has no register source, only a destination.
      OP_LUI: dec_dest = rt;
      OP_JAL: dec_dest = RA_REG;
      default: ;
    endcase
  end

  // Writes to $0 are discarded, so they never create a hazard.
  assign dec_entry.valid   = (dec_dest != 5'd0);
  assign dec_entry.dest    = dec_dest;
  assign dec_entry.is_load = dec_load & (dec_dest != 5'd0);

  // ---------------- hazard detection ----------------
  logic dwait, loaduse, run_active;

  assign dwait   = (dmemREN_MEM | dmemWEN_MEM) & ~dhit;
  assign loaduse = ex_q.valid & ex_q.is_load &
                   ((uses_rs & (rs == ex_q.dest)) | (uses_rt & (rt == ex_q.dest)));

  // Controls are forced quiet while reset is held, not just after it.
  assign run_active = (state_q == ST_RUN) & ~RST;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (run_active) begin
      if (dwait) begin
        // Freeze everything upstream of MEM; WB receives a bubble.
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (redirect_EX) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (loaduse) begin
        // Hold PC and IF/ID so the consumer re-decodes next cycle.
        {idex_en, exmem_en, memwb_en} = 3'b111;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
        ifid_flush = 1'b1;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      end
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    state_d = state_q;
    stall_d = stall_q;
    if (state_q == ST_RUN) begin
      if (memwb_flush)   wb_d = '0;
      else if (memwb_en) wb_d = mem_q;

      // Anything leaving EX (including a bubble) replaces MEM.
      if (exmem_en) mem_d = ex_q;

      if (idex_flush)   ex_d = '0;
      else if (idex_en) ex_d = dec_entry;

      if (!pc_en) stall_d = stall_q + CNT_W'(1);
      if (halt_WB) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign halted       = (state_q == ST_HALTED);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
//   Directed-vector bench for hazard_stall_unit. Each cycle applies one
//   instruction plus status inputs and compares the packed control vector
//   {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//    ifid_flush, idex_flush, memwb_flush} against hand-computed values.
module tb_hazard_stall_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] instr_ID = 32'd0;
  logic        ihit = 1'b1, dhit = 1'b1;
  logic        dmemREN_MEM = 1'b0, dmemWEN_MEM = 1'b0;
  logic        redirect_EX = 1'b0, halt_WB = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, memwb_flush, halted;
  logic [31:0] stall_cycles;
  logic [7:0]  ctl;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  hazard_stall_unit dut (
    .CLK(CLK), .RST(RST), .instr_ID(instr_ID), .ihit(ihit), .dhit(dhit),
    .dmemREN_MEM(dmemREN_MEM), .dmemWEN_MEM(dmemWEN_MEM),
    .redirect_EX(redirect_EX), .halt_WB(halt_WB),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, memwb_flush};

  // Expected control vectors
  localparam logic [7:0] C_NORM  = 8'hF8;
  localparam logic [7:0] C_DWAIT = 8'h09;
  localparam logic [7:0] C_REDIR = 8'hFE;
  localparam logic [7:0] C_LDUSE = 8'h3A;
  localparam logic [7:0] C_IWAIT = 8'h7C;
  localparam logic [7:0] C_ZERO  = 8'h00;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One pipeline cycle: drive just after the edge, check mid-cycle.
  task automatic cyc(input string tag, input logic [31:0] ins,
                     input logic ih, dh, ren, wen, redir, hlt,
                     input logic [7:0] exp_ctl);
    @(posedge CLK);
    #1;
    instr_ID    = ins;
    ihit        = ih;
    dhit        = dh;
    dmemREN_MEM = ren;
    dmemWEN_MEM = wen;
    redirect_EX = redir;
    halt_WB     = hlt;
    #2;
    check_eq(tag, {24'd0, ctl}, {24'd0, exp_ctl});
  endtask

  logic [31:0] nop, lw2, add_324, lw0, add_300, sw_2_5, lui_7, lw9, add_399, lw4, add_504;

  initial begin
    nop     = 32'd0;
    lw2     = enc_i(6'h23, 5'd1, 5'd2, 16'd0);
    add_324 = enc_r(5'd2, 5'd4, 5'd3, 6'h20);
    lw0     = enc_i(6'h23, 5'd1, 5'd0, 16'd0);
    add_300 = enc_r(5'd0, 5'd0, 5'd3, 6'h20);
    sw_2_5  = enc_i(6'h2B, 5'd5, 5'd2, 16'd0);
    lui_7   = enc_i(6'h0F, 5'd2, 5'd7, 16'h1234);
    lw9     = enc_i(6'h23, 5'd1, 5'd9, 16'd4);
    add_399 = enc_r(5'd9, 5'd9, 5'd3, 6'h20);
    lw4     = enc_i(6'h23, 5'd1, 5'd4, 16'd8);
    add_504 = enc_r(5'd0, 5'd4, 5'd5, 6'h20);

    // Reset held across a clock edge
    @(posedge CLK);
    #1;
    check_eq("rst_ctl", {24'd0, ctl}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_stall", stall_cycles, 32'd0);
    RST = 1'b0;

    // Load-use on rs
    cyc("lw2",          lw2,     1,1,0,0,0,0, C_NORM);
    cyc("loaduse_rs",   add_324, 1,1,0,0,0,0, C_LDUSE);
    cyc("after_lduse",  add_324, 1,1,0,0,0,0, C_NORM);
    check_eq("stall_1", stall_cycles, 32'd1);

    // Destination $0 never stalls
    cyc("lw0",          lw0,     1,1,0,0,0,0, C_NORM);
    cyc("dest0_nostall",add_300, 1,1,0,0,0,0, C_NORM);

    // SW uses rt as a source
    cyc("lw2_b",        lw2,     1,1,0,0,0,0, C_NORM);
    cyc("loaduse_rt_sw",sw_2_5,  1,1,0,0,0,0, C_LDUSE);
    cyc("sw_retry",     sw_2_5,  1,1,0,0,0,0, C_NORM);
    check_eq("stall_2", stall_cycles, 32'd2);

    // LUI has no rs source even when the rs field matches
    cyc("lw2_c",        lw2,     1,1,0,0,0,0, C_NORM);
    cyc("lui_no_rs",    lui_7,   1,1,0,0,0,0, C_NORM);

    // Data wait for 3 cycles freezes EX (load still in EX afterwards)
    cyc("lw9",          lw9,     1,1,0,0,0,0, C_NORM);
    cyc("dwait_1",      add_399, 1,0,1,0,0,0, C_DWAIT);
    cyc("dwait_2",      add_399, 1,0,1,0,0,0, C_DWAIT);
    cyc("dwait_3",      add_399, 1,0,1,0,0,0, C_DWAIT);
    cyc("lduse_post_dw",add_399, 1,1,0,0,0,0, C_LDUSE);
    cyc("resume",       add_399, 1,1,0,0,0,0, C_NORM);
    check_eq("stall_6", stall_cycles, 32'd6);
    cyc("dwait_store",  nop,     1,0,0,1,0,0, C_DWAIT);

    // Redirect priority
    cyc("redir_ihit0",  nop,     0,1,0,0,1,0, C_REDIR);
    check_eq("stall_7", stall_cycles, 32'd7);
    cyc("dwait_beats_redir", nop,0,0,1,0,1,0, C_DWAIT);
    cyc("iwait",        nop,     0,1,0,0,0,0, C_IWAIT);
    cyc("lw4",          lw4,     1,1,0,0,0,0, C_NORM);
    check_eq("stall_9", stall_cycles, 32'd9);
    cyc("lduse_beats_iwait", add_504, 0,1,0,0,0,0, C_LDUSE);
    cyc("after_lduse2", add_504, 1,1,0,0,0,0, C_NORM);
    check_eq("stall_10", stall_cycles, 32'd10);

    // Halt
    cyc("halt_cycle",   nop,     1,1,0,0,0,1, C_NORM);
    check_eq("not_yet_halted", {31'd0, halted}, 32'd0);
    cyc("halted_ctl",   nop,     0,1,0,0,0,0, C_ZERO);
    check_eq("halted", {31'd0, halted}, 32'd1);
    cyc("halted_ctl2",  nop,     1,1,0,0,0,0, C_ZERO);
    check_eq("halted_nocount", stall_cycles, 32'd10);

    // Asynchronous reset while halted
    #1 RST = 1'b1;
    #1;
    check_eq("rst_halted_clr", {31'd0, halted}, 32'd0);
    check_eq("rst_stall_clr", stall_cycles, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    cyc("run_after_rst", nop,    1,1,0,0,0,0, C_NORM);
    check_eq("run_not_halted", {31'd0, halted}, 32'd0);

    // Asynchronous reset during a load-use stall
    cyc("lw2_d",        lw2,     1,1,0,0,0,0, C_NORM);
    cyc("loaduse_pre_rst", add_324, 1,1,0,0,0,0, C_LDUSE);
    #1 RST = 1'b1;
    #1;
    check_eq("rst_async_ctl", {24'd0, ctl}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    cyc("no_residual",  add_324, 1,1,0,0,0,0, C_NORM);
    check_eq("stall_after_rst", stall_cycles, 32'd0);
    cyc("final_nop",    nop,     1,1,0,0,0,0, C_NORM);
    check_eq("stall_final", stall_cycles, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
